// File: rtl/inst_sram_bridge.sv
// inst_sram_bridge: fetch-side responder for the IF stage. It translates virtual
// fetch addresses, fills a one-word buffer from a variable-latency read port,
// stalls the pipeline until the requested word is held, and returns the word
// one cycle after the accepting cycle.
module inst_sram_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  output logic        stallreq,
  output logic        wr_err,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic        rd_ready,
  input  logic        rd_rvalid,
  input  logic [31:0] rd_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state;
  logic        buf_valid;
  logic [31:0] buf_addr;
  logic [31:0] buf_data;
  logic [31:0] req_addr;
  logic        hit;
  logic        wdata_unused;

  // kseg0/kseg1 (0x8000_0000-0xBFFF_FFFF) fold onto physical memory by
  // clearing the top three bits; every other segment passes through.
  function automatic logic [31:0] translate(input logic [31:0] va);
    if (va[31:30] == 2'b10) begin
      return {3'b000, va[28:0]};
    end
    return va;
  endfunction

  // Instruction memory is read-only, so a buffered word may be reused freely.
  assign hit          = buf_valid && (buf_addr == inst_sram_addr);
  assign stallreq     = inst_sram_en && !hit;
  assign wdata_unused = ^inst_sram_wdata;

  // Sticky write-attempt flag; the offending request is still served as a read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_err <= 1'b0;
    end else if (inst_sram_en && (inst_sram_wen != 4'h0)) begin
      wr_err <= 1'b1;
    end
  end

  // Return path: the buffered word is presented the cycle after an accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_sram_rdata <= 32'h0;
    end else if (inst_sram_en && hit) begin
      inst_sram_rdata <= buf_data;
    end
  end

  // Fill FSM: one outstanding read; a started fill always completes for req_addr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rd_req    <= 1'b0;
      rd_addr   <= 32'h0;
      req_addr  <= 32'h0;
      buf_valid <= 1'b0;
      buf_addr  <= 32'h0;
      buf_data  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (inst_sram_en && !hit) begin
            req_addr  <= inst_sram_addr;
            rd_addr   <= translate(inst_sram_addr);
            rd_req    <= 1'b1;
            buf_valid <= 1'b0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (rd_ready) begin
            rd_req <= 1'b0;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (rd_rvalid) begin
            buf_data  <= rd_rdata;
            buf_addr  <= req_addr;
            buf_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_sram_bridge.sv
// Bench for inst_sram_bridge: table of fetch vectors against a configurable
// memory responder, plus hand-written mid-fill and reset-in-WAIT sequences.
module tb_inst_sram_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_sram_en = 1'b0;
  logic [3:0]  inst_sram_wen = 4'h0;
  logic [31:0] inst_sram_addr = 32'h0;
  logic [31:0] inst_sram_wdata = 32'h0;
  logic [31:0] inst_sram_rdata;
  logic        stallreq;
  logic        wr_err;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_ready = 1'b0;
  logic        rd_rvalid = 1'b0;
  logic [31:0] rd_rdata = 32'h0;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  int          mem_st = 0;
  int          cnt = 0;
  int          lcnt = 0;
  int          ready_dly = 0;
  int          lat = 1;
  int          req_count = 0;
  logic [31:0] hold = 32'h0;
  logic        exp_wr = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wen;
    int          rdy;
    int          lat;
    logic        miss;
    int          stalls;
    logic [31:0] rd;
  } vec_t;

  always #5 clk = ~clk;

  inst_sram_bridge dut (
    .clk             (clk),
    .rst             (rst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .stallreq        (stallreq),
    .wr_err          (wr_err),
    .rd_req          (rd_req),
    .rd_addr         (rd_addr),
    .rd_ready        (rd_ready),
    .rd_rvalid       (rd_rvalid),
    .rd_rdata        (rd_rdata)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] pa);
    if (pa == 32'h1FC0_0000) return 32'h2408_0001;
    return {pa[15:0], pa[31:16]} ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory model: holds rd_ready low ready_dly cycles, returns data lat cycles
  // after the handshake. Keeps running through DUT reset on purpose.
  initial begin
    forever begin
      @(posedge clk); #1;
      rd_ready  = 1'b0;
      rd_rvalid = 1'b0;
      if (mem_st == 0 && rd_req === 1'b1) begin
        mem_st = 1;
        cnt    = ready_dly;
        hold   = rd_addr;
        req_count++;
      end
      if (mem_st == 1) begin
        chk("rd_addr_stable", rd_addr, hold);
        chk("rd_req_held", {31'b0, rd_req}, 32'h1);
        if (cnt == 0) begin
          rd_ready = 1'b1;
          mem_st   = 2;
          lcnt     = lat;
        end else begin
          cnt--;
        end
      end else if (mem_st == 2) begin
        if (lcnt <= 1) begin
          rd_rvalid = 1'b1;
          rd_rdata  = mem_fn(hold);
          mem_st    = 0;
        end else begin
          lcnt--;
        end
      end
    end
  end

  // Called at posedge+1 with a request already driven; counts stall cycles,
  // then checks the returned word one cycle after the accept.
  task automatic wait_accept(input string nm, input logic [31:0] exp_data, output int st);
    st = 0;
    forever begin
      @(negedge clk);
      if (!stallreq) break;
      st++;
      if (st > 60) begin
        checks++;
        failures++;
        $display("FAIL %s_timeout: stallreq got 1 expected 0", nm);
        break;
      end
      @(posedge clk); #1;
    end
    exp_q.push_back(exp_data);
    @(posedge clk); #1;
    inst_sram_en  = 1'b0;
    inst_sram_wen = 4'h0;
    @(negedge clk);
    chk({nm, "_rdata"}, inst_sram_rdata, exp_q.pop_front());
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t tbl[8];
    int   st;
    int   rc0;
    int   g;

    tbl[0] = '{32'hBFC0_0000, 4'h0, 0, 1, 1'b1, 3, 32'h1FC0_0000};
    tbl[1] = '{32'h8000_0100, 4'h0, 2, 3, 1'b1, 7, 32'h0000_0100};
    tbl[2] = '{32'h1000_0000, 4'h0, 0, 1, 1'b1, 3, 32'h1000_0000};
    tbl[3] = '{32'h1000_0000, 4'h0, 0, 1, 1'b0, 0, 32'h1000_0000};
    tbl[4] = '{32'h1000_0000, 4'hF, 0, 1, 1'b0, 0, 32'h1000_0000};
    tbl[5] = '{32'hC000_0004, 4'h0, 0, 2, 1'b1, 4, 32'hC000_0004};
    tbl[6] = '{32'h7FFF_FFFC, 4'h0, 1, 1, 1'b1, 4, 32'h7FFF_FFFC};
    tbl[7] = '{32'hBFFF_FFFC, 4'h0, 0, 1, 1'b1, 3, 32'h1FFF_FFFC};

    inst_sram_wdata = $urandom;

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", inst_sram_rdata, 32'h0);
    chk("rst_stallreq", {31'b0, stallreq}, 32'h0);
    chk("rst_wr_err", {31'b0, wr_err}, 32'h0);
    chk("rst_rd_req", {31'b0, rd_req}, 32'h0);
    chk("rst_rd_addr", rd_addr, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Table-driven fetches
    for (int i = 0; i < 8; i++) begin
      ready_dly      = tbl[i].rdy;
      lat            = tbl[i].lat;
      rc0            = req_count;
      inst_sram_en   = 1'b1;
      inst_sram_addr = tbl[i].addr;
      inst_sram_wen  = tbl[i].wen;
      if (tbl[i].wen != 4'h0) exp_wr = 1'b1;
      wait_accept($sformatf("vec%0d", i), mem_fn(tbl[i].rd), st);
      chk($sformatf("vec%0d_stalls", i), st, tbl[i].stalls);
      chk($sformatf("vec%0d_reqs", i), req_count - rc0, {31'b0, tbl[i].miss});
      if (tbl[i].miss) chk($sformatf("vec%0d_rd_addr", i), hold, tbl[i].rd);
      chk($sformatf("vec%0d_wr_err", i), {31'b0, wr_err}, {31'b0, exp_wr});
    end

    // Address change while the fill for A is in WAIT
    ready_dly      = 0;
    lat            = 3;
    rc0            = req_count;
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'hBFC0_0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    inst_sram_addr = 32'hBFC0_0010;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("mid_buf_addr", dut.buf_addr, 32'hBFC0_0000);
    chk("mid_buf_data", dut.buf_data, mem_fn(32'h1FC0_0000));
    lat = 1;
    wait_accept("midfill", mem_fn(32'h1FC0_0010), st);
    chk("midfill_reqs", req_count - rc0, 32'd2);
    chk("midfill_rd_addr", hold, 32'h1FC0_0010);

    // Asynchronous reset while waiting for read data
    ready_dly      = 0;
    lat            = 4;
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'h0000_0040;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    rst = 1'b0;
    #1;
    chk("wait_rst_rd_req", {31'b0, rd_req}, 32'h0);
    chk("wait_rst_buf_valid", {31'b0, dut.buf_valid}, 32'h0);
    chk("wait_rst_rdata", inst_sram_rdata, 32'h0);
    chk("wait_rst_wr_err", {31'b0, wr_err}, 32'h0);
    inst_sram_en = 1'b0;
    exp_wr       = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    g = 0;
    while (mem_st != 0 && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    chk("late_rvalid_delivered", mem_st, 32'd0);
    @(posedge clk); #1;
    chk("late_buf_valid", {31'b0, dut.buf_valid}, 32'h0);
    chk("late_stallreq", {31'b0, stallreq}, 32'h0);
    ready_dly      = 0;
    lat            = 1;
    rc0            = req_count;
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'h0000_0040;
    wait_accept("post_rst", mem_fn(32'h0000_0040), st);
    chk("post_rst_stalls", st, 32'd3);
    chk("post_rst_reqs", req_count - rc0, 32'd1);
    chk("post_rst_rd_addr", hold, 32'h0000_0040);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
